// File: rtl/pll_reset_sequencer.sv
// Sequences NUM_RESETS synchronous active-high resets off a synchronized PLL/MMCM LOCKED.
// Optional lock-timeout PLL reset pulse enabled by PLL_RESET_SEQUENCER_TIMEOUT_EN.
module pll_reset_sequencer #(
  parameter int unsigned NUM_RESETS    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned RELEASE_GAP   = 16
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
  ,
  parameter int unsigned LOCK_TIMEOUT   = 131072,
  parameter int unsigned PLL_RST_CYCLES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock_async,
  output logic                  pll_rst,
  output logic [NUM_RESETS-1:0] rst_out,
  output logic                  ready,
  output logic [7:0]            lock_loss_count
);

  localparam int unsigned STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned GAP_W    = $clog2(RELEASE_GAP + 1);
  localparam int unsigned IDX_W    = $clog2(NUM_RESETS + 1);
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
  localparam int unsigned TO_W     = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned PULSE_W  = $clog2(PLL_RST_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABLE    = 3'd1,
    RELEASE   = 3'd2,
    RUNNING   = 3'd3,
    PLL_RESET = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                  lock_s;
  logic [STABLE_W-1:0]   stable_q, stable_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_RESETS-1:0] rst_out_q, rst_out_d;
  logic                  ready_q, ready_d;
  logic [7:0]            loss_q, loss_d;
  logic                  start_release;
  logic                  lose;
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
  logic [TO_W-1:0]       timeout_q, timeout_d;
  logic [PULSE_W-1:0]    pulse_q, pulse_d;
  logic                  pll_rst_q, pll_rst_d;
`endif

  // Lock synchronizer; cleared by rst so lock is always re-qualified from scratch
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock_async};
  end
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d       = state_q;
    stable_d      = stable_q;
    gap_d         = gap_q;
    idx_d         = idx_q;
    rst_out_d     = rst_out_q;
    ready_d       = ready_q;
    loss_d        = loss_q;
    start_release = 1'b0;
    lose          = 1'b0;
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
    // Timeout and pulse counters only advance in their own state, so they restart on every entry
    timeout_d     = '0;
    pulse_d       = '0;
    pll_rst_d     = 1'b0;
`endif

    case (state_q)
      WAIT_LOCK: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (lock_s) begin
          if (STABLE_CYCLES == 1) begin
            start_release = 1'b1;
          end else begin
            state_d  = STABLE;
            stable_d = STABLE_W'(1);
          end
        end
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
        else if (timeout_q == TO_W'(LOCK_TIMEOUT - 1)) begin
          state_d   = PLL_RESET;
          pll_rst_d = 1'b1;
        end else begin
          timeout_d = timeout_q + TO_W'(1);
        end
`endif
      end
      STABLE: begin
        if (!lock_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
        end else if (stable_q == STABLE_W'(STABLE_CYCLES - 1)) begin
          start_release = 1'b1;
        end else begin
          stable_d = stable_q + STABLE_W'(1);
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          lose = 1'b1;
        end else if (gap_q == GAP_W'(RELEASE_GAP - 1)) begin
          rst_out_d = rst_out_q & ~(NUM_RESETS'(1) << idx_q);
          gap_d     = '0;
          if (idx_q == IDX_W'(NUM_RESETS - 1)) begin
            state_d = RUNNING;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      RUNNING: begin
        if (!lock_s) lose = 1'b1;
      end
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
      PLL_RESET: begin
        rst_out_d = '1;
        ready_d   = 1'b0;
        if (pulse_q == PULSE_W'(PLL_RST_CYCLES - 1)) begin
          state_d = WAIT_LOCK;
        end else begin
          pll_rst_d = 1'b1;
          pulse_d   = pulse_q + PULSE_W'(1);
        end
      end
`endif
      default: begin
        state_d   = WAIT_LOCK;
        rst_out_d = '1;
        ready_d   = 1'b0;
      end
    endcase

    // First release: bit 0 drops on the edge the stability window completes
    if (start_release) begin
      stable_d  = '0;
      gap_d     = '0;
      rst_out_d = ~NUM_RESETS'(1);
      if (NUM_RESETS == 1) begin
        state_d = RUNNING;
        ready_d = 1'b1;
        idx_d   = '0;
      end else begin
        state_d = RELEASE;
        idx_d   = IDX_W'(1);
      end
    end

    if (lose) begin
      state_d   = WAIT_LOCK;
      rst_out_d = '1;
      ready_d   = 1'b0;
      stable_d  = '0;
      gap_d     = '0;
      idx_d     = '0;
      if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_LOCK;
      stable_q  <= '0;
      gap_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      ready_q   <= 1'b0;
      loss_q    <= '0;
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
      timeout_q <= '0;
      pulse_q   <= '0;
      pll_rst_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      stable_q  <= stable_d;
      gap_q     <= gap_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      ready_q   <= ready_d;
      loss_q    <= loss_d;
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
      timeout_q <= timeout_d;
      pulse_q   <= pulse_d;
      pll_rst_q <= pll_rst_d;
`endif
    end
  end

  assign rst_out         = rst_out_q;
  assign ready           = ready_q;
  assign lock_loss_count = loss_q;
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
  assign pll_rst         = pll_rst_q;
`else
  assign pll_rst         = 1'b0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: expectations are queued with their due cycle
// when stimulus is applied, then popped and compared when that cycle's outputs settle.
module tb_pll_reset_sequencer;

  localparam int unsigned NR = 3;

  logic          clk;
  logic          rst;
  logic          pll_lock_async;
  logic          pll_rst;
  logic [NR-1:0] rst_out;
  logic          ready;
  logic [7:0]    lock_loss_count;

  typedef struct {
    int          at;
    logic [12:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   errors;
  int   checks;

  pll_reset_sequencer #(
    .NUM_RESETS    (NR),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .RELEASE_GAP   (4)
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
    ,
    .LOCK_TIMEOUT  (32),
    .PLL_RST_CYCLES(4)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pll_lock_async (pll_lock_async),
    .pll_rst        (pll_rst),
    .rst_out        (rst_out),
    .ready          (ready),
    .lock_loss_count(lock_loss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [12:0] pack(logic [2:0] r, logic rd, logic [7:0] c, logic p);
    return {r, rd, c, p};
  endfunction

  // Queue an expectation due 'off' active edges from now
  task automatic push(input int off, input logic [2:0] r, input logic rd,
                      input logic [7:0] c, input logic p, input string tag);
    exp_t e;
    e.at  = cyc + off;
    e.exp = pack(r, rd, c, p);
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Advance n edges; compare every expectation due at each edge on the following falling edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        exp_t        e;
        logic [12:0] obs;
        e   = sb.pop_front();
        obs = pack(rst_out, ready, lock_loss_count, pll_rst);
        checks++;
        assert (obs === e.exp && e.at == cyc)
        else begin
          errors++;
          $error("FAIL %s @cyc %0d: observed rst_out=%b ready=%b count=%0d pll_rst=%b, expected rst_out=%b ready=%b count=%0d pll_rst=%b (due %0d)",
                 e.tag, cyc, obs[12:10], obs[9], obs[8:1], obs[0],
                 e.exp[12:10], e.exp[9], e.exp[8:1], e.exp[0], e.at);
        end
      end
    end
  endtask

  initial begin
    int c;
    cyc            = 0;
    errors         = 0;
    checks         = 0;
    rst            = 1'b1;
    pll_lock_async = 1'b0;

    // Reset state
    push(1, 3'b111, 1'b0, 8'd0, 1'b0, "reset_state");
    tick(2);

    // Lock held from the first edge after reset: releases at 10, 14, 18
    rst            = 1'b0;
    pll_lock_async = 1'b1;
    push(9,  3'b111, 1'b0, 8'd0, 1'b0, "t1_hold_edge9");
    push(10, 3'b110, 1'b0, 8'd0, 1'b0, "t1_bit0_edge10");
    push(13, 3'b110, 1'b0, 8'd0, 1'b0, "t1_gap_edge13");
    push(14, 3'b100, 1'b0, 8'd0, 1'b0, "t1_bit1_edge14");
    push(17, 3'b100, 1'b0, 8'd0, 1'b0, "t1_gap_edge17");
    push(18, 3'b000, 1'b1, 8'd0, 1'b0, "t1_ready_edge18");
    tick(20);

    // One-cycle lock drop while running: all resets back after 3 edges, sequence reruns
    pll_lock_async = 1'b0;
    push(2, 3'b000, 1'b1, 8'd0, 1'b0, "t3_still_running");
    push(3, 3'b111, 1'b0, 8'd1, 1'b0, "t3_loss_reassert");
    tick(1);
    pll_lock_async = 1'b1;
    push(9,  3'b111, 1'b0, 8'd1, 1'b0, "t3_rerun_hold");
    push(10, 3'b110, 1'b0, 8'd1, 1'b0, "t3_rerun_bit0");
    push(14, 3'b100, 1'b0, 8'd1, 1'b0, "t3_rerun_bit1");
    push(18, 3'b000, 1'b1, 8'd1, 1'b0, "t3_rerun_ready");
    tick(20);

    // Repeated losses right after bit 0 release; counter saturates at 255
    for (int n = 1; n <= 300; n++) begin
      c = (n + 1 > 255) ? 255 : n + 1;
      pll_lock_async = 1'b0;
      push(3,  3'b111, 1'b0, 8'(c), 1'b0, "t4_loss_mid_release");
      push(11, 3'b110, 1'b0, 8'(c), 1'b0, "t4_bit0_again");
      tick(1);
      pll_lock_async = 1'b1;
      tick(10);
    end
    push(4, 3'b100, 1'b0, 8'd255, 1'b0, "t4_saturated_bit1");
    tick(4);

    // rst mid-release overrides everything; release restarts with lock still high
    rst = 1'b1;
    push(1, 3'b111, 1'b0, 8'd0, 1'b0, "t5_rst_override");
    tick(1);
    rst = 1'b0;
    push(9,  3'b111, 1'b0, 8'd0, 1'b0, "t5_hold");
    push(10, 3'b110, 1'b0, 8'd0, 1'b0, "t5_release_plus10");
    tick(12);

    // Short glitch during stability window restarts the count without a loss event
    rst            = 1'b1;
    pll_lock_async = 1'b0;
    tick(2);
    rst            = 1'b0;
    pll_lock_async = 1'b1;
    tick(5);
    pll_lock_async = 1'b0;
    tick(1);
    pll_lock_async = 1'b1;
    push(4,  3'b111, 1'b0, 8'd0, 1'b0, "t2_no_early_release");
    push(9,  3'b111, 1'b0, 8'd0, 1'b0, "t2_hold_after_rerise");
    push(10, 3'b110, 1'b0, 8'd0, 1'b0, "t2_release_after_rerise");
    tick(12);

    // PLL reset pulse behaviour with lock absent
    rst            = 1'b1;
    pll_lock_async = 1'b0;
    tick(2);
    rst = 1'b0;
`ifdef PLL_RESET_SEQUENCER_TIMEOUT_EN
    push(31, 3'b111, 1'b0, 8'd0, 1'b0, "t6_before_timeout");
    push(32, 3'b111, 1'b0, 8'd0, 1'b1, "t6_pulse_start");
    push(35, 3'b111, 1'b0, 8'd0, 1'b1, "t6_pulse_last");
    push(36, 3'b111, 1'b0, 8'd0, 1'b0, "t6_pulse_end");
    push(67, 3'b111, 1'b0, 8'd0, 1'b0, "t6_before_repeat");
    push(68, 3'b111, 1'b0, 8'd0, 1'b1, "t6_repeat_start");
    push(71, 3'b111, 1'b0, 8'd0, 1'b1, "t6_repeat_last");
    push(72, 3'b111, 1'b0, 8'd0, 1'b0, "t6_repeat_end");
    tick(75);
`else
    for (int k = 100; k <= 1000; k += 100)
      push(k, 3'b111, 1'b0, 8'd0, 1'b0, "t6_pll_rst_low");
    tick(1000);
`endif

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: check due at cycle %0d never reached (observed none, expected %h)", e.tag, e.at, e.exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
